// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface multicycle_controller_if;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cond;
   logic [3:0] instr74;
   logic [3:0] alu_flags;

   logic       pc_write;
   logic       ir_write;
   logic       adr_src;
   logic       mem_write;
   logic       reg_write3;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic [1:0] result_src;
   logic [2:0] alu_ctl;
   logic [3:0] mul_ctl;
   logic       carry;
   logic       busy;

   // Datapath side: supplies instruction fields and ALU flags, consumes controls.
   modport master (
      output op, funct, cond, instr74, alu_flags,
      input  pc_write, ir_write, adr_src, mem_write, reg_write3,
      input  alu_src_a, alu_src_b, imm_src, reg_src, result_src,
      input  alu_ctl, mul_ctl, carry, busy
   );

   // Controller side.
   modport slave (
      input  op, funct, cond, instr74, alu_flags,
      output pc_write, ir_write, adr_src, mem_write, reg_write3,
      output alu_src_a, alu_src_b, imm_src, reg_src, result_src,
      output alu_ctl, mul_ctl, carry, busy
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle ARM-subset datapath with an optional
// fixed-latency multiply step.
module multicycle_controller #(
   parameter int unsigned MUL_LATENCY = 3,
   parameter bit          ENABLE_MUL  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.slave bus
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      MULEX  = 4'd8,
      ALUWB  = 4'd9,
      BRANCH = 4'd10
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       flags_q, flags_d;
   logic             cond_ex_q, cond_ex_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             from_mul_q, from_mul_d;

   logic             cond_true_c;
   logic             pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write3_c;
   logic [1:0]       alu_src_a_c, alu_src_b_c, result_src_c;
   logic [2:0]       alu_ctl_c;
   logic [3:0]       mul_ctl_c;

   // Data-processing ALU operation from funct[4:1]; compares/tests reuse SUB/AND.
   function automatic logic [2:0] dp_alu_ctl(input logic [3:0] f);
      case (f)
         4'b0100: dp_alu_ctl = 3'b000;
         4'b0010: dp_alu_ctl = 3'b001;
         4'b0000: dp_alu_ctl = 3'b010;
         4'b1100: dp_alu_ctl = 3'b011;
         4'b0101: dp_alu_ctl = 3'b100;
         4'b1010: dp_alu_ctl = 3'b001;
         4'b1000: dp_alu_ctl = 3'b010;
         default: dp_alu_ctl = 3'b000;
      endcase
   endfunction

   // ARM condition evaluation against the stored {N,Z,C,V}.
   always_comb begin
      logic n, z, c, v;
      n = flags_q[3];
      z = flags_q[2];
      c = flags_q[1];
      v = flags_q[0];
      case (bus.cond)
         4'b0000: cond_true_c = z;
         4'b0001: cond_true_c = ~z;
         4'b0010: cond_true_c = c;
         4'b0011: cond_true_c = ~c;
         4'b0100: cond_true_c = n;
         4'b0101: cond_true_c = ~n;
         4'b0110: cond_true_c = v;
         4'b0111: cond_true_c = ~v;
         4'b1000: cond_true_c = c & ~z;
         4'b1001: cond_true_c = ~c | z;
         4'b1010: cond_true_c = (n == v);
         4'b1011: cond_true_c = (n != v);
         4'b1100: cond_true_c = ~z & (n == v);
         4'b1101: cond_true_c = z | (n != v);
         default: cond_true_c = 1'b1;
      endcase
   end

   // State, flags, condition and multiply-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         flags_q    <= '0;
         cond_ex_q  <= 1'b0;
         cnt_q      <= '0;
         from_mul_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         cond_ex_q  <= cond_ex_d;
         cnt_q      <= cnt_d;
         from_mul_q <= from_mul_d;
      end
   end

   // Next-state logic and Moore outputs.
   always_comb begin
      state_d      = state_q;
      flags_d      = flags_q;
      cond_ex_d    = cond_ex_q;
      cnt_d        = cnt_q;
      from_mul_d   = 1'b0;
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      adr_src_c    = 1'b0;
      mem_write_c  = 1'b0;
      reg_write3_c = 1'b0;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      result_src_c = 2'b00;
      alu_ctl_c    = 3'b000;
      mul_ctl_c    = 4'b0000;

      case (state_q)
         FETCH: begin
            ir_write_c   = 1'b1;
            pc_write_c   = 1'b1;
            alu_src_a_c  = 2'b10;
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            state_d      = DECODE;
         end
         DECODE: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b10;
            cond_ex_d   = cond_true_c;
            case (bus.op)
               2'b01: state_d = MEMADR;
               2'b10: state_d = BRANCH;
               2'b00: begin
                  if (bus.funct[5]) begin
                     state_d = EXECI;
                  end else if (ENABLE_MUL && (bus.instr74 == 4'b1001)) begin
                     state_d = MULEX;
                     cnt_d   = CNT_W'(MUL_LATENCY - 1);
                  end else begin
                     state_d = EXECR;
                  end
               end
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_b_c = 2'b01;
            alu_ctl_c   = bus.funct[3] ? 3'b000 : 3'b001;
            state_d     = bus.funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            adr_src_c = 1'b1;
            state_d   = MEMWB;
         end
         MEMWB: begin
            result_src_c = 2'b01;
            reg_write3_c = cond_ex_q;
            state_d      = FETCH;
         end
         MEMWR: begin
            adr_src_c   = 1'b1;
            mem_write_c = cond_ex_q;
            state_d     = FETCH;
         end
         EXECR, EXECI: begin
            alu_src_b_c = (state_q == EXECI) ? 2'b01 : 2'b00;
            alu_ctl_c   = dp_alu_ctl(bus.funct[4:1]);
            state_d     = ALUWB;
            if (bus.funct[0] && cond_ex_q) begin
               flags_d = bus.alu_flags;
            end
         end
         MULEX: begin
            mul_ctl_c = {1'b1, bus.funct[3:1]};
            if (cnt_q == '0) begin
               state_d    = ALUWB;
               from_mul_d = 1'b1;
               if (bus.funct[0] && cond_ex_q) begin
                  flags_d = bus.alu_flags;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ALUWB: begin
            result_src_c = from_mul_q ? 2'b11 : 2'b00;
            mul_ctl_c    = from_mul_q ? {1'b1, bus.funct[3:1]} : 4'b0000;
            reg_write3_c = cond_ex_q & (bus.funct[4:3] != 2'b10);
            state_d      = FETCH;
         end
         BRANCH: begin
            alu_src_b_c  = 2'b01;
            result_src_c = 2'b10;
            pc_write_c   = cond_ex_q;
            state_d      = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are gated by reset so nothing commits while it is held.
   assign bus.pc_write   = pc_write_c & reset;
   assign bus.ir_write   = ir_write_c & reset;
   assign bus.mem_write  = mem_write_c & reset;
   assign bus.reg_write3 = reg_write3_c & reset;
   assign bus.adr_src    = adr_src_c;
   assign bus.alu_src_a  = alu_src_a_c;
   assign bus.alu_src_b  = alu_src_b_c;
   assign bus.result_src = result_src_c;
   assign bus.alu_ctl    = alu_ctl_c;
   assign bus.mul_ctl    = mul_ctl_c;
   assign bus.imm_src    = bus.op;
   assign bus.reg_src    = {bus.op == 2'b01, bus.op == 2'b10};
   assign bus.carry      = flags_q[1];
   assign bus.busy       = (state_q != FETCH);

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MUL_LATENCY, default 3, range 1..8: number of MULEX cycles per multiply.
REQ-002 Parameter ENABLE_MUL, default 1: 0 decodes the multiply pattern as an ordinary EXECR data-processing instruction.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 The ports SHALL be:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20]
- cond  in  4  instr[31:28]
- instr74  in  4  instr[7:4]
- alu_flags  in  4  {N,Z,C,V}
- pc_write, ir_write, adr_src, mem_write, reg_write3  out  1  datapath enables/selects
- alu_src_a, alu_src_b, imm_src, reg_src, result_src  out  2  mux selects
- alu_ctl  out  3  ADD=000, SUB=001, AND=010, ORR=011, ADC=100
- mul_ctl  out  4  multiplier control
- carry  out  1  stored C flag for ADC
- busy  out  1  high in every state except FETCH

Function
REQ-005 The FSM SHALL be Moore with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULEX, ALUWB, BRANCH.
REQ-006 FETCH SHALL drive ir_write=1, pc_write=1, adr_src=0, alu_src_a=10, alu_src_b=10, alu_ctl=000, result_src=10, and SHALL go to DECODE.
REQ-007 DECODE SHALL drive the PC+4 ALU selects of REQ-006 with no enables, and SHALL latch cond_ex_q = condition(cond, flags_q).
REQ-008 DECODE next state SHALL be:
- op=01 -> MEMADR
- op=10 -> BRANCH
- op=00, funct[5]=1 -> EXECI
- op=00, funct[5]=0, instr74=1001, ENABLE_MUL=1 -> MULEX
- other op=00 -> EXECR
- op=11 -> FETCH
REQ-009 MEMADR SHALL drive alu_src_a=00, alu_src_b=01, imm_src=01, and alu_ctl=000 if funct[3]=1 else 001; next state MEMRD if funct[0]=1, else MEMWR.
REQ-010 MEMRD SHALL drive adr_src=1 and go to MEMWB. MEMWB SHALL drive result_src=01, reg_write3=cond_ex_q, and go to FETCH.
REQ-011 MEMWR SHALL drive adr_src=1, mem_write=cond_ex_q, and go to FETCH.
REQ-012 EXECR (alu_src_b=00) and EXECI (alu_src_b=01, imm_src=00) SHALL drive alu_src_a=00 and go to ALUWB.
REQ-013 alu_ctl in EXECR/EXECI SHALL decode from funct[4:1]: 0100->000, 0010->001, 0000->010, 1100->011, 0101->100, 1010(CMP)->001, 1000(TST)->010, others->000.
REQ-014 At the clock edge leaving EXECR/EXECI/MULEX, flags_q SHALL load alu_flags iff funct[0]=1 and cond_ex_q=1.
REQ-015 MULEX SHALL hold for exactly MUL_LATENCY cycles using a down-counter loaded with MUL_LATENCY-1 on entry, then go to ALUWB.
REQ-016 mul_ctl SHALL be {1'b1, funct[3:1]} in MULEX and in ALUWB reached from MULEX; otherwise 0000.
REQ-017 ALUWB SHALL drive result_src=11 if reached from MULEX, else 00, and SHALL go to FETCH.
REQ-018 ALUWB SHALL drive reg_write3=cond_ex_q, forced 0 when funct[4:3]=10 (CMP/TST class).
REQ-019 BRANCH SHALL drive alu_src_a=00, alu_src_b=01, imm_src=10, result_src=10, pc_write=cond_ex_q, and go to FETCH.
REQ-020 imm_src and reg_src SHALL be combinational from op in all states: imm_src=op; reg_src[0]=(op==10); reg_src[1]=(op==01).
REQ-021 carry SHALL equal flags_q[1] at all times.
REQ-022 Condition codes SHALL follow the ARM encoding (EQ..LE). AL=1110 and 1111 SHALL both evaluate true.
REQ-023 Outputs not listed for a state SHALL be 0.

Reset
REQ-024 While reset=0, the block SHALL hold state=FETCH, flags_q=0000, cond_ex_q=0, counter=0.
REQ-025 While reset=0, pc_write, ir_write, mem_write and reg_write3 SHALL be forced to 0.
REQ-026 Reset asserted mid-instruction, including mid-MULEX, SHALL abort immediately without flag or register update.
REQ-027 The first rising edge after reset release SHALL execute FETCH.

Verification
REQ-028 ADD, cond=1110, funct=001000: FETCH->DECODE->EXECR->ALUWB. 4 cycles total; reg_write3=1 only in ALUWB.
REQ-029 SUBS then CMP setting Z:
- SUBS with alu_flags=0100 -> flags_q=0100
- following BNE (cond=0001) -> pc_write=0 in BRANCH
- following BEQ -> pc_write=1 in BRANCH
REQ-030 LDR (op=01, funct=011001): 5 cycles. MEMWB result_src=01, reg_write3=1.
REQ-031 STR with cond=0000 and Z=0: mem_write stays 0 in MEMWR.
REQ-032 MUL (funct=000000, instr74=1001), MUL_LATENCY=1 and 3:
- MULEX lasts 1 or 3 cycles
- mul_ctl=1000
- ALUWB result_src=11
- with ENABLE_MUL=0, EXECR is taken instead.
REQ-033 ADCS after flags_q C=1: carry=1 and alu_ctl=100 in EXECR. Reset pulsed during MULEX -> FETCH, flags_q=0000.
